muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle sequencer for the RV32M multiply/divide operations. It replaces the single-cycle combinational multiply/divide path of the core ALU with an iterative shift-add multiplier and a restoring divider, each built from one WIDTH-bit adder/subtractor. Sits beside the ALU in the execute stage. The core stalls on req_ready/resp_valid and may abort an operation with kill on a pipeline flush.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.
FAST_SPECIAL, 1, when 1, divide-by-zero and signed-overflow divides bypass iteration.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_a  input  WIDTH  rs1 operand
req_b  input  WIDTH  rs2 operand
kill  input  1  abort the in-flight operation
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_result  output  WIDTH  result
busy  output  1  state is not IDLE

Behaviour:
- Clock, reset and state encoding:
  - One clock domain: clk. Reset rst_n is asynchronous and active-low.
  - On reset: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, busy=0, counter=0, internal accumulators=0.
- States:
  - IDLE -> CALC on req_valid&&req_ready. Operands, op and signs are latched at that edge.
  - IDLE -> DONE directly on a special divide when FAST_SPECIAL=1.
  - CALC -> DONE after the counter reaches WIDTH-1.
  - DONE -> IDLE on resp_ready.
- Handshake:
  - req_ready=1 only in IDLE.
  - resp_valid=1 only in DONE. resp_result holds stable while resp_valid=1 and resp_ready=0.
  - A new request is not accepted in the cycle DONE exits; there is no back-to-back overlap.
- Latency:
  - Request accepted at edge N; resp_valid rises after edge N+WIDTH+1 (33 cycles for WIDTH=32).
  - Special-case latency is 1 cycle: resp_valid after edge N+1.
- Operand preparation:
  - Signed operand: a for MULH/MULHSU/DIV/REM; b for MULH/DIV/REM.
  - A signed operand with MSB=1 is negated to its magnitude. The result sign is recorded.
- Multiply:
  - 2*WIDTH-bit product register. Each CALC cycle: if multiplier LSB=1, add the multiplicand into the upper half; then shift right by 1 with carry-in.
  - At completion, the product is negated (two's complement over 2*WIDTH bits) if sign_a^sign_b.
  - MUL returns the low WIDTH bits. MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide (restoring):
  - Each cycle: shift {rem,quot} left by 1; trial-subtract the divisor from rem; if no borrow, keep the difference and set quot LSB=1.
  - Quotient is negated if sign_a^sign_b. Remainder is negated if sign_a.
- Boundary cases (exact RISC-V results, same with FAST_SPECIAL=0 via the iterative path plus final fix-up):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = req_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- kill:
  - In CALC or DONE, the next state is IDLE with resp_valid=0. No result is emitted.
  - kill in IDLE is ignored. If kill and req_valid are both high in IDLE, the request is accepted (kill targets only prior ops).
- Misc:
  - busy = (state != IDLE).
  - Reset asserted mid-operation clears everything immediately, without waiting for the clock.
  - req_* inputs are ignored outside IDLE. req_op is sampled once at acceptance.

Test Plan:
- Reset mid-CALC at cycle 10 of MULHU -> outputs are at their reset values asynchronously; after release, req_ready=1 and no stale resp_valid.
- MUL 7*6; MULH 0xFFFFFFFF*0xFFFFFFFF; MULHSU 0xFFFFFFFF*0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 42, 0, 0xFFFFFFFF, 0xFFFFFFFE respectively; each arrives exactly 33 cycles after acceptance.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. With FAST_SPECIAL=1 each arrives 1 cycle after acceptance.
- resp_ready held low 5 cycles after resp_valid -> result stable, req_ready=0; resp_ready=1 -> IDLE next cycle and the next request is accepted.
- kill at cycle 15 of DIV -> IDLE next cycle, resp_valid never asserts; a following MUL 3*3 returns 9 with normal latency.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit. A shift-add multiplier and a restoring divider
// share one 2*WIDTH-bit accumulator. Operands are converted to magnitudes on entry and signs are fixed up at the end.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// CALC   | one multiply/divide iteration per cycle, WIDTH cycles
// FINISH | sign fix-up / special-case selection into resp_result
// DONE   | resp_valid high until resp_ready (or kill)
module muldiv_seq #(
    parameter int WIDTH        = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic [2:0]         op;
    logic               sign_a, sign_b, div_zero, div_ovf;

    logic               accept, is_div_req, a_signed, b_signed, ovf_req, special;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, result;

    // Request decode: which operands are signed and whether the divide is a special case
    always_comb begin
        accept     = (state == IDLE) && req_valid;
        is_div_req = req_op[2];
        a_signed   = (req_op == 3'b001) || (req_op == 3'b010) ||
                     (req_op == 3'b100) || (req_op == 3'b110);
        b_signed   = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
        a_mag      = (a_signed && req_a[WIDTH-1]) ? -req_a : req_a;
        b_mag      = (b_signed && req_b[WIDTH-1]) ? -req_b : req_b;
        ovf_req    = is_div_req && !req_op[0] &&
                     (req_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&req_b);
        special    = is_div_req && ((req_b == '0) || ovf_req);
    end

    // Shared iteration arithmetic: multiplier add into the upper half, divider trial subtract
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = rem_sh - {1'b0, operand};
    end

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        result   = '0;
        if (op[2]) begin
            // Special divides override whatever the iterations produced (or skipped)
            if (div_zero)
                result = op[1] ? a_raw : '1;
            else if (div_ovf)
                result = op[1] ? '0 : a_raw;
            else
                result = op[1] ? rem_fix : quot_fix;
        end else begin
            result = (op[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    state_nxt = (FAST_SPECIAL && special) ? FINISH : CALC;
            end
            CALC: begin
                if (kill)
                    state_nxt = IDLE;
                else if (count == CW'(WIDTH-1))
                    state_nxt = FINISH;
            end
            FINISH: begin
                state_nxt = kill ? IDLE : DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (kill || resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            acc         <= '0;
            operand     <= '0;
            a_raw       <= '0;
            op          <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            div_zero    <= 1'b0;
            div_ovf     <= 1'b0;
            resp_result <= '0;
        end else if (accept) begin
            count    <= '0;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            operand  <= b_mag;
            a_raw    <= req_a;
            op       <= req_op;
            sign_a   <= a_signed & req_a[WIDTH-1];
            sign_b   <= b_signed & req_b[WIDTH-1];
            div_zero <= is_div_req & (req_b == '0);
            div_ovf  <= ovf_req;
        end else if (state == CALC) begin
            count <= count + CW'(1);
            if (op[2]) begin
                if (!div_diff[WIDTH])
                    acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                if (acc[0])
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                else
                    acc <= {1'b0, acc[2*WIDTH-1:1]};
            end
        end else if (state == FINISH) begin
            resp_result <= result;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic reference model, per-cycle response monitor,
// latency, back-pressure, kill and asynchronous reset scenarios.
module tb_muldiv_seq;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_result = '0;
    bit          resp_expected = 1'b0;

    muldiv_seq #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .kill        (kill),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference results straight from the RISC-V arithmetic definitions
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub, q;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'(b);
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin q = sa / sb; p = q; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else begin q = sa % sb; p = q; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_result = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            check("ready_vs_busy", req_ready, !busy);
            if (!resp_expected)
                check("spurious_resp_valid", resp_valid, 1'b0);
            else if (resp_valid)
                check("resp_vs_model", resp_result, exp_result);
            if (resp_valid && prev_valid && !prev_ready)
                check("resp_stable", resp_result, prev_result);
            prev_valid  = resp_valid;
            prev_ready  = resp_ready;
            prev_result = resp_result;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit kill_req);
        @(negedge clk);
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        kill      = kill_req;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int exp_lat,
                         input int hold, input bit kill_req);
        logic [31:0] m;
        int          lat;
        bit          got;
        m = model(op, a, b);
        check({name, "_model"}, m, lit);
        exp_result    = m;
        resp_expected = 1'b1;
        resp_ready    = (hold == 0);
        issue(op, a, b, kill_req);
        lat = 0;
        got = 1'b0;
        if (resp_valid) got = 1'b1;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (resp_valid) got = 1'b1;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, resp_result, lit);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, resp_valid, 1'b1);
            check({name, "_hold_ready"}, req_ready, 1'b0);
            check({name, "_hold_result"}, resp_result, lit);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_pop_valid"}, resp_valid, 1'b0);
        check({name, "_pop_ready"}, req_ready, 1'b1);
        resp_expected = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion within 400us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        kill       = 1'b0;
        resp_ready = 1'b1;
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", resp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul_7x6",       3'd0, 32'd7,        32'd6,        32'd42,       33, 0, 1'b0);
        do_op("mulh_m1xm1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0, 1'b0);
        do_op("mulhsu_m1xmax", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, 1'b0);
        do_op("mulhu_max",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, 1'b0);
        do_op("mul_min_m1",    3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0, 1'b0);
        do_op("mulh_min_min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0, 1'b0);
        do_op("div_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0, 1'b0);
        do_op("rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0, 1'b0);
        do_op("divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       33, 5, 1'b0);
        do_op("remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        33, 0, 1'b0);
        do_op("div_m100_7",    3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33, 0, 1'b0);
        do_op("rem_m100_7",    3'd6, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33, 0, 1'b0);
        do_op("div_by_zero",   3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 1,  0, 1'b0);
        do_op("remu_by_zero",  3'd7, 32'd7,        32'd0,        32'd7,        1,  0, 1'b0);
        do_op("div_overflow",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, 1'b0);
        do_op("rem_overflow",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0, 1'b0);

        // kill lands at the 15th CALC edge of a divide; no response may follow
        resp_expected = 1'b0;
        issue(3'd4, 32'd100, 32'd7, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", busy, 1'b0);
        check("kill_req_ready", req_ready, 1'b1);
        check("kill_resp_valid", resp_valid, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("kill_no_resp", resp_valid, 1'b0);
        do_op("mul_after_kill", 3'd0, 32'd3, 32'd3, 32'd9, 33, 0, 1'b1);

        // asynchronous reset in the middle of a MULHU
        resp_expected = 1'b0;
        issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 1'b0);
        check("arst_req_ready", req_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_result", resp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", req_ready, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_no_resp", resp_valid, 1'b0);
        do_op("mulhu_after_rst", 3'd3, 32'hFFFFFFFF, 32'd2, 32'd1, 33, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
